// File: rtl/shifter_arbiter_if.sv
// shifter_arbiter_if: requester-side and result-side handshake bundle for shifter_arbiter
interface shifter_arbiter_if #(
    parameter int CTRL  = 3,
    parameter int WIDTH = 2**CTRL,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ*CTRL-1:0]  req_shift;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [IDW-1:0]        out_id;

    modport master (
        output req_valid, req_data, req_shift, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_data, req_shift, out_ready,
        output req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/shifter_arbiter.sv
// shifter_arbiter: round-robin arbiter feeding one shared rotate-left unit into a single result register
module shifter_arbiter #(
    parameter int CTRL  = 3,
    parameter int WIDTH = 2**CTRL,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    shifter_arbiter_if.slave bus
);
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d, gnt_idx, out_id_q;
    logic               gnt_any, can_load, xfer, out_valid_q;
    logic [WIDTH-1:0]   sel_data, out_data_q, out_data_d;
    logic [CTRL-1:0]    sel_shift;
    logic [2*WIDTH-1:0] dbl;
    int                 start, lo, hi, g;
    logic               lo_hit, hi_hit;

    // Two-pass search: lowest valid at or above the pointer, else lowest valid overall (wrap).
    always_comb begin
        start  = (int'(rr_ptr_q) >= NREQ) ? 0 : int'(rr_ptr_q);
        lo     = 0;
        hi     = 0;
        lo_hit = 1'b0;
        hi_hit = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                lo     = i;
                lo_hit = 1'b1;
            end
            if (bus.req_valid[i] && i >= start) begin
                hi     = i;
                hi_hit = 1'b1;
            end
        end
        g       = hi_hit ? hi : lo;
        gnt_any = lo_hit;
        gnt_idx = IDW'(g);
    end

    assign sel_data      = bus.req_data[g*WIDTH +: WIDTH];
    assign sel_shift     = bus.req_shift[g*CTRL +: CTRL];
    assign dbl           = {sel_data, sel_data} << sel_shift;
    assign out_data_d    = dbl[2*WIDTH-1:WIDTH];
    assign can_load      = !out_valid_q || bus.out_ready;
    assign xfer          = rst_n && gnt_any && can_load;
    assign rr_ptr_d      = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    assign bus.req_ready = xfer ? NREQ'(1) << gnt_idx : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= out_data_d;
            out_id_q    <= gnt_idx;
            rr_ptr_q    <= rr_ptr_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule
